pix_row_packer: RTL and testbench
=================================

Name: pix_row_packer

Overview:
- Clocked transmitter that feeds the pixel-memory PEs.
- Accepts a serial pixel stream and packs each group of 5 pixels into one frame of DWIDTH*5 bits. The first pixel accepted goes in the top slot [DWIDTH*5-1 : DWIDTH*4]; the fifth pixel goes in the bottom slot [DWIDTH-1 : 0].
- Issues each frame on a valid/ready output, tagged with a round-robin destination PE index and an end-of-image flag.
- Sits between the image source and the per-PE pixel frame inputs.

Parameters:
- DWIDTH, 8, bits per pixel.
- NUM_PE, 3, number of destination PEs; range 1..16.
- ROWS_PER_IMG, 5, frames (rows) per image; range 1..1024.
- FIFO_DEPTH, 2, output frame buffer entries; must be a power of 2, at least 2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pix_in_data  in  DWIDTH  serial pixel.
- pix_in_valid  in  1  pixel offered.
- pix_in_ready  out  1  pixel accepted when valid && ready.
- frame_out_data  out  DWIDTH*5  packed frame; slot [4] is the first pixel received.
- frame_out_valid  out  1  frame offered.
- frame_out_ready  in  1  downstream accepts.
- frame_out_dest  out  max(1,$clog2(NUM_PE))  destination PE index.
- frame_out_last  out  1  frame is the final row of an image.
- busy  out  1  partial frame held, or FIFO not empty.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - column counter = 0, row counter = 0, dest counter = 0.
  - FIFO emptied; partial frame discarded.
  - Outputs: pix_in_ready=0 during reset and 1 on the first cycle after release; frame_out_valid=0, frame_out_data=0, frame_out_dest=0, frame_out_last=0, busy=0.
- Packing:
  - On each accepted pixel, write it into slot (4 - col), then col <= col+1.
  - On the accept where col==4: push {assembled frame, dest, last} into the FIFO, and set col <= 0.
  - The assembled frame must include the pixel accepted this cycle, written combinationally into slot 0.
- Latency: the frame appears on frame_out_* the cycle after the 5th pixel is accepted, when the FIFO was empty.
- Input backpressure:
  - pix_in_ready = !(col==4 && fifo_full && !(frame_out_valid && frame_out_ready)).
  - For col<4 the block always accepts.
  - A simultaneous pop and push on a full FIFO is legal and must not stall.
- Output handshake:
  - frame_out_valid = FIFO not empty.
  - The head entry is held stable until frame_out_ready is seen high; data, dest and last must not change while valid is high and ready is low.
  - Pop on valid && ready.
- Tagging (evaluated at push):
  - dest = dest counter, which wraps NUM_PE-1 -> 0 and increments on every push.
  - last = (row == ROWS_PER_IMG-1); row wraps to 0 after the last row.
  - The dest counter is NOT reset at an image boundary; it continues round-robin.
- Width rules: counters are sized to their maximum value; no arithmetic on pixel data.
- busy = (col != 0) || FIFO not empty.
- Reset mid-frame or with the FIFO full: all state is discarded and nothing is emitted.

Optional Feature:
- Macro: PIX_ROW_PACKER_STATS_EN.
- When defined, two extra output ports are added:
  - stat_frames (32 bit): counts frames popped.
  - stat_stall (32 bit): counts cycles with frame_out_valid && !frame_out_ready.
- Both counters saturate at all-ones and clear on reset.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package pix_pkg:
  - FRAME_PIX=5.
  - typedef pix_t [DWIDTH-1:0].
  - typedef frame_t [DWIDTH*FRAME_PIX-1:0].
  - struct frame_entry_t {frame_t data; dest; last}.
- Sub-module pix_frame_fifo: FIFO_DEPTH-entry synchronous FIFO of frame_entry_t with full/empty flags and simultaneous push/pop.
- The top level holds the column, row and dest counters and the packing register.

Test Plan:
- Basic pack: ready held high; send pixels 10,20,30,40,50.
  - Response: one cycle after the 5th accept, frame_out_data = {10,20,30,40,50} (slot4=10), dest=0, last=0.
- Round robin and last (NUM_PE=3, ROWS_PER_IMG=5): send 35 pixels (7 frames).
  - dest sequence 0,1,2,0,1,2,0.
  - last=1 on frames 5 only among the first five, then on none of frames 6-7.
  - Row 0 restarts at frame 6.
- Backpressure: hold frame_out_ready=0 and send 15 pixels.
  - Two frames are buffered; pix_in_ready drops when the 15th pixel is pending (col==4, FIFO full).
  - Head frame stays stable.
  - Raise ready: the frames drain in order and the 15th pixel is accepted in the same cycle as the first pop.
- Simultaneous push and pop: FIFO full, ready=1, 5th pixel valid.
  - No stall cycle; FIFO count is unchanged.
- Reset mid-op: 3 pixels in and 1 frame buffered; pulse rst_n low asynchronously between clock edges.
  - Outputs are immediately at reset values; busy=0.
  - The next 5 pixels form a frame with dest=0.
- Stats (PIX_ROW_PACKER_STATS_EN): 2 frames, with 4 stall cycles on the first.
  - stat_frames=2, stat_stall=4.

Source files
------------

// File: rtl/pix_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pix_pkg
// Description : Shared constants, pixel/frame types and width helper for the
//               pixel row packer.
// Revision    : 1.0 - initial release
// ============================================================================
package pix_pkg;

    localparam int FRAME_PIX  = 5;
    localparam int PKG_DWIDTH = 8;
    localparam int PKG_DEST_W = 2;

    typedef logic [PKG_DWIDTH-1:0]           pix_t;
    typedef logic [PKG_DWIDTH*FRAME_PIX-1:0] frame_t;

    typedef struct packed {
        frame_t                data;
        logic [PKG_DEST_W-1:0] dest;
        logic                  last;
    } frame_entry_t;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int min_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pix_frame_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pix_frame_fifo
// Description : Small synchronous FIFO of frame entries with full/empty flags;
//               a push on a full FIFO is honoured when a pop happens alongside.
// Revision    : 1.0 - initial release
// ============================================================================
module pix_frame_fifo
    import pix_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type ENTRY_T = frame_entry_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_push,
    input  ENTRY_T i_push_data,
    input  logic   i_pop,
    output ENTRY_T o_head,
    output logic   o_full,
    output logic   o_empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic [c_AW:0] r_wr_ptr;
    logic [c_AW:0] r_rd_ptr;
    ENTRY_T        r_mem [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/pix_row_packer.sv
`default_nettype none
// ============================================================================
// Module      : pix_row_packer
// Description : Packs a serial pixel stream into 5-pixel frames, tags each
//               frame with a round-robin PE index and an end-of-image flag.
//               Optional macro PIX_ROW_PACKER_STATS_EN adds frame/stall stats.
// Revision    : 1.0 - initial release
// ============================================================================
module pix_row_packer
    import pix_pkg::*;
#(
    parameter int DWIDTH       = 8,
    parameter int NUM_PE       = 3,
    parameter int ROWS_PER_IMG = 5,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [DWIDTH-1:0]                 pix_in_data,
    input  logic                              pix_in_valid,
    output logic                              pix_in_ready,
    output logic [DWIDTH*FRAME_PIX-1:0]       frame_out_data,
    output logic                              frame_out_valid,
    input  logic                              frame_out_ready,
    output logic [min_width(NUM_PE)-1:0]      frame_out_dest,
    output logic                              frame_out_last,
    output logic                              busy
`ifdef PIX_ROW_PACKER_STATS_EN
    ,
    output logic [31:0]                       stat_frames,
    output logic [31:0]                       stat_stall
`endif
);

    localparam int c_FW     = DWIDTH * FRAME_PIX;
    localparam int c_DEST_W = min_width(NUM_PE);
    localparam int c_ROW_W  = min_width(ROWS_PER_IMG);

    localparam logic [2:0]          c_LAST_COL  = 3'(FRAME_PIX - 1);
    localparam logic [c_ROW_W-1:0]  c_LAST_ROW  = c_ROW_W'(ROWS_PER_IMG - 1);
    localparam logic [c_DEST_W-1:0] c_LAST_DEST = c_DEST_W'(NUM_PE - 1);

    typedef struct packed {
        logic [c_FW-1:0]     data;
        logic [c_DEST_W-1:0] dest;
        logic                last;
    } entry_t;

    logic [2:0]             r_col;
    logic [c_ROW_W-1:0]     r_row;
    logic [c_DEST_W-1:0]    r_dest;
    // Only the first four pixels are stored; the fifth joins combinationally.
    logic [c_FW-DWIDTH-1:0] r_frame;

    logic   w_col_last;
    logic   w_accept;
    logic   w_push;
    logic   w_pop;
    logic   w_fifo_full;
    logic   w_fifo_empty;
    logic [1:0] w_slot;
    entry_t w_push_entry;
    entry_t w_head;

    assign w_col_last      = (r_col == c_LAST_COL);
    assign frame_out_valid = !w_fifo_empty;
    assign w_pop           = frame_out_valid && frame_out_ready;
    assign pix_in_ready    = rst_n && !(w_col_last && w_fifo_full && !w_pop);
    assign w_accept        = pix_in_valid && pix_in_ready;
    assign w_push          = w_accept && w_col_last;
    assign w_slot          = 2'd3 - r_col[1:0];

    always_comb begin
        w_push_entry      = '0;
        w_push_entry.data = {r_frame, pix_in_data};
        w_push_entry.dest = r_dest;
        w_push_entry.last = (r_row == c_LAST_ROW);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col   <= '0;
            r_row   <= '0;
            r_dest  <= '0;
            r_frame <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col  <= '0;
                r_row  <= (r_row == c_LAST_ROW) ? '0 : r_row + 1'b1;
                r_dest <= (r_dest == c_LAST_DEST) ? '0 : r_dest + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
                r_frame[32'(w_slot) * DWIDTH +: DWIDTH] <= pix_in_data;
            end
        end
    end

    pix_frame_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .ENTRY_T (entry_t)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    // Head is masked so an empty FIFO always presents zeros.
    assign frame_out_data = frame_out_valid ? w_head.data : '0;
    assign frame_out_dest = frame_out_valid ? w_head.dest : '0;
    assign frame_out_last = frame_out_valid ? w_head.last : 1'b0;
    assign busy           = (r_col != 3'd0) || !w_fifo_empty;

`ifdef PIX_ROW_PACKER_STATS_EN
    logic [31:0] r_stat_frames;
    logic [31:0] r_stat_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_frames <= '0;
            r_stat_stall  <= '0;
        end else begin
            if (w_pop && (r_stat_frames != '1))
                r_stat_frames <= r_stat_frames + 1'b1;
            if (frame_out_valid && !frame_out_ready && (r_stat_stall != '1))
                r_stat_stall <= r_stat_stall + 1'b1;
        end
    end

    assign stat_frames = r_stat_frames;
    assign stat_stall  = r_stat_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pix_row_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pix_row_packer
// Description : Randomised and directed bench for pix_row_packer against a
//               queue-based frame model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pix_row_packer;

    localparam int DW   = 8;
    localparam int NPE  = 3;
    localparam int ROWS = 5;
    localparam int FD   = 2;
    localparam int FW   = DW * 5;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] pix_in_data;
    logic          pix_in_valid;
    logic          pix_in_ready;
    logic [FW-1:0] frame_out_data;
    logic          frame_out_valid;
    logic          frame_out_ready;
    logic [1:0]    frame_out_dest;
    logic          frame_out_last;
    logic          busy;
`ifdef PIX_ROW_PACKER_STATS_EN
    logic [31:0]   stat_frames;
    logic [31:0]   stat_stall;
`endif

    pix_row_packer #(
        .DWIDTH       (DW),
        .NUM_PE       (NPE),
        .ROWS_PER_IMG (ROWS),
        .FIFO_DEPTH   (FD)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pix_in_data     (pix_in_data),
        .pix_in_valid    (pix_in_valid),
        .pix_in_ready    (pix_in_ready),
        .frame_out_data  (frame_out_data),
        .frame_out_valid (frame_out_valid),
        .frame_out_ready (frame_out_ready),
        .frame_out_dest  (frame_out_dest),
        .frame_out_last  (frame_out_last),
        .busy            (busy)
`ifdef PIX_ROW_PACKER_STATS_EN
        ,
        .stat_frames     (stat_frames),
        .stat_stall      (stat_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pixels of the frame under assembly and frames awaiting pop.
    typedef struct {
        logic [FW-1:0] data;
        int            dest;
        bit            last;
    } exp_t;

    logic [DW-1:0] m_pix[$];
    exp_t          m_q[$];
    int            m_nfr;
    int            m_pops;
    int            m_stalls;
    int            pop_dest[$];
    int            pop_last[$];

    always @(negedge clk) begin : cmp
        int   col;
        int   occ;
        bit   pop;
        bit   exp_ready;
        exp_t e;
        if (!rst_n) begin
            check("rst_ready", 64'(pix_in_ready), 64'(0));
            check("rst_valid", 64'(frame_out_valid), 64'(0));
            check("rst_data",  64'(frame_out_data), 64'(0));
            check("rst_dest",  64'(frame_out_dest), 64'(0));
            check("rst_last",  64'(frame_out_last), 64'(0));
            check("rst_busy",  64'(busy), 64'(0));
            m_pix.delete();
            m_q.delete();
            pop_dest.delete();
            pop_last.delete();
            m_nfr    = 0;
            m_pops   = 0;
            m_stalls = 0;
        end else begin
            col       = m_pix.size();
            occ       = m_q.size();
            pop       = (occ > 0) && frame_out_ready;
            exp_ready = !(col == 4 && occ == FD && !pop);
            check("ready", 64'(pix_in_ready), 64'(exp_ready));
            check("valid", 64'(frame_out_valid), 64'(occ > 0));
            check("busy",  64'(busy), 64'(col != 0 || occ != 0));
`ifdef PIX_ROW_PACKER_STATS_EN
            check("stat_frames", 64'(stat_frames), 64'(m_pops));
            check("stat_stall",  64'(stat_stall), 64'(m_stalls));
`endif
            if (occ > 0) begin
                check("data", 64'(frame_out_data), 64'(m_q[0].data));
                check("dest", 64'(frame_out_dest), 64'(m_q[0].dest));
                check("last", 64'(frame_out_last), 64'(m_q[0].last));
                if (!frame_out_ready) m_stalls++;
            end
            if (pop) begin
                pop_dest.push_back(int'(frame_out_dest));
                pop_last.push_back(int'(frame_out_last));
                void'(m_q.pop_front());
                m_pops++;
            end
            if (pix_in_valid && exp_ready) begin
                m_pix.push_back(pix_in_data);
                if (m_pix.size() == 5) begin
                    e.data = {m_pix[0], m_pix[1], m_pix[2], m_pix[3], m_pix[4]};
                    e.dest = m_nfr % NPE;
                    e.last = ((m_nfr % ROWS) == ROWS - 1);
                    m_nfr++;
                    m_q.push_back(e);
                    m_pix.delete();
                end
            end
        end
    end

    // Offers one pixel and returns at posedge+1 of the accepting edge.
    task automatic send_pix(input logic [DW-1:0] d);
        bit acc;
        int t;
        pix_in_data  = d;
        pix_in_valid = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            acc = pix_in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            t++;
            if (t > 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_timeout: got no accept, expected accept within 200 cycles");
                break;
            end
        end
        pix_in_valid = 1'b0;
    endtask

    task automatic do_reset();
        pix_in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_dest [7] = '{0, 1, 2, 0, 1, 2, 0};
        int exp_last [7] = '{0, 0, 0, 0, 1, 0, 0};
        logic [7:0] basic [5] = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50};

        rst_n           = 1'b0;
        pix_in_valid    = 1'b0;
        pix_in_data     = '0;
        frame_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic pack: frame visible the cycle after the fifth accept.
        for (int i = 0; i < 5; i++) send_pix(basic[i]);
        check("basic_valid", 64'(frame_out_valid), 64'(1));
        check("basic_data",  64'(frame_out_data), 64'h0A141E2832);
        check("basic_dest",  64'(frame_out_dest), 64'(0));
        check("basic_last",  64'(frame_out_last), 64'(0));
        repeat (2) @(posedge clk);

        // Round robin and end-of-image across seven frames.
        do_reset();
        for (int i = 0; i < 35; i++) send_pix(8'(i + 1));
        repeat (3) @(posedge clk);
        check("rr_count", 64'(pop_dest.size()), 64'(7));
        for (int i = 0; i < 7 && i < pop_dest.size(); i++) begin
            check("rr_dest", 64'(pop_dest[i]), 64'(exp_dest[i]));
            check("rr_last", 64'(pop_last[i]), 64'(exp_last[i]));
        end

        // Backpressure: two frames buffered, fifteenth pixel stalls.
        do_reset();
        frame_out_ready = 1'b0;
        for (int i = 0; i < 14; i++) send_pix(8'(i + 1));
        pix_in_data  = 8'd15;
        pix_in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_stall", 64'(pix_in_ready), 64'(0));
            check("bp_head",  64'(frame_out_data), 64'h0102030405);
        end
        @(posedge clk);
        #1 frame_out_ready = 1'b1;
        @(negedge clk);
        check("bp_release", 64'(pix_in_ready), 64'(1));
        @(posedge clk);
        #1 pix_in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("bp_drained", 64'(busy), 64'(0));

        // Simultaneous push and pop on a full FIFO.
        frame_out_ready = 1'b0;
        for (int i = 0; i < 14; i++) send_pix(8'(8'h20 + i));
        pix_in_data     = 8'h2E;
        pix_in_valid    = 1'b1;
        frame_out_ready = 1'b1;
        @(negedge clk);
        check("simul_no_stall", 64'(pix_in_ready), 64'(1));
        @(posedge clk);
        #1 pix_in_valid = 1'b0;
        check("simul_count2", 64'(frame_out_valid), 64'(1));
        @(posedge clk);
        #1 check("simul_count1", 64'(frame_out_valid), 64'(1));
        @(posedge clk);
        #1 check("simul_count0", 64'(frame_out_valid), 64'(0));

        // Asynchronous reset with one frame buffered and three pixels held.
        frame_out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_pix(8'(8'h40 + i));
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(frame_out_valid), 64'(0));
        check("mid_rst_busy",  64'(busy), 64'(0));
        check("mid_rst_data",  64'(frame_out_data), 64'(0));
        check("mid_rst_ready", 64'(pix_in_ready), 64'(0));
        @(posedge clk);
        #2 rst_n = 1'b1;
        frame_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send_pix(8'(8'h51 + i));
        check("post_rst_data", 64'(frame_out_data), 64'h5152535455);
        check("post_rst_dest", 64'(frame_out_dest), 64'(0));
        repeat (2) @(posedge clk);

`ifdef PIX_ROW_PACKER_STATS_EN
        do_reset();
        frame_out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_pix(8'(i));
        repeat (4) @(posedge clk);
        #1 frame_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send_pix(8'(i + 5));
        repeat (3) @(posedge clk);
        #1;
        check("stat_frames_lit", 64'(stat_frames), 64'(2));
        check("stat_stall_lit",  64'(stat_stall), 64'(4));
`endif

        // Random traffic on both sides.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            pix_in_valid    = ($urandom_range(0, 9) < 7);
            pix_in_data     = 8'($urandom);
            frame_out_ready = ($urandom_range(0, 9) < 6);
        end
        @(posedge clk);
        #1;
        pix_in_valid    = 1'b0;
        frame_out_ready = 1'b1;
        repeat (6) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
